// File: rtl/i2c_scl_gen.sv
// I2C master SCL generator: divides clk into a four-phase bit period, drives
// SCL open-drain, provides data_clk for the SDA shifter and synchronises to
// slaves that stretch SCL, with a sticky timeout for a stuck bus.
module i2c_scl_gen #(
  parameter int DIVIDER         = 250,
  parameter int CBITS           = 12,
  parameter int STRETCH_TIMEOUT = 4096,
  parameter int TBITS           = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       scl_in,
  output logic       scl_oe,
  output logic       data_clk,
  output logic [1:0] phase,
  output logic       phase_stb,
  output logic       stretching,
  output logic       timeout
);

  localparam logic [CBITS-1:0] CNT_Q1   = CBITS'(DIVIDER);
  localparam logic [CBITS-1:0] CNT_Q2   = CBITS'(2 * DIVIDER);
  localparam logic [CBITS-1:0] CNT_Q3   = CBITS'(3 * DIVIDER);
  localparam logic [CBITS-1:0] CNT_LAST = CBITS'(4 * DIVIDER - 1);
  localparam logic [TBITS-1:0] HELD_MAX = TBITS'(STRETCH_TIMEOUT);

  logic [CBITS-1:0] cnt;
  logic [CBITS-1:0] cnt_nxt;
  logic [TBITS-1:0] held;
  logic [1:0]       phase_nxt;
  logic             at_mid_low;
  logic             hold;
  logic             expire;

  // Next counter value, hold/abort decision and phase decode of the new count.
  // Once a stretch has timed out the bus is treated as dead: no further holds
  // until the generator is disabled or reset.
  always_comb begin
    at_mid_low = (cnt == CNT_Q2) && !scl_in && !timeout;
    hold       = at_mid_low && (held < HELD_MAX);
    expire     = at_mid_low && !hold;
    if (hold)
      cnt_nxt = cnt;
    else if (cnt == CNT_LAST)
      cnt_nxt = '0;
    else
      cnt_nxt = cnt + CBITS'(1);
    if (cnt_nxt >= CNT_Q3)
      phase_nxt = 2'd3;
    else if (cnt_nxt >= CNT_Q2)
      phase_nxt = 2'd2;
    else if (cnt_nxt >= CNT_Q1)
      phase_nxt = 2'd1;
    else
      phase_nxt = 2'd0;
  end

  // Counter, stretch tracking and registered outputs; idle parks the counter
  // one step before zero so the first enabled edge starts a fresh period.
  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      cnt        <= CNT_LAST;
      held       <= '0;
      timeout    <= 1'b0;
      scl_oe     <= 1'b0;
      data_clk   <= 1'b0;
      phase      <= 2'd0;
      phase_stb  <= 1'b0;
      stretching <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      held       <= hold ? held + TBITS'(1) : '0;
      if (expire)
        timeout  <= 1'b1;
      scl_oe     <= (phase_nxt == 2'd0) || (phase_nxt == 2'd1);
      data_clk   <= (phase_nxt == 2'd1) || (phase_nxt == 2'd2);
      phase      <= phase_nxt;
      phase_stb  <= !hold && ((cnt_nxt == '0) || (cnt_nxt == CNT_Q1) ||
                              (cnt_nxt == CNT_Q2) || (cnt_nxt == CNT_Q3));
      stretching <= hold;
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Bench for i2c_scl_gen with DIVIDER=4, STRETCH_TIMEOUT=16: a constant vector
// table, hand-written period/stretch/timeout sequences, and random stimulus
// compared against a behavioural model every cycle.
module tb_i2c_scl_gen;
  localparam int D  = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       scl_in;
  logic       scl_oe, data_clk, phase_stb, stretching, timeout;
  logic [1:0] phase;

  int  n_chk  = 0;
  int  n_fail = 0;

  // scl_in source: 0 = bench-forced, 1 = ~scl_oe directly, 2 = ~scl_oe via 2 flops
  int   mode      = 0;
  logic scl_force = 1'b1;
  logic d1 = 1'b1, d2 = 1'b1;

  assign scl_in = (mode == 0) ? scl_force : (mode == 1) ? ~scl_oe : d2;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= ~scl_oe;
    d2 <= d1;
  end

  i2c_scl_gen #(.DIVIDER(D), .CBITS(4), .STRETCH_TIMEOUT(TO), .TBITS(5)) dut (
    .clk(clk), .rst(rst), .ena(ena), .scl_in(scl_in),
    .scl_oe(scl_oe), .data_clk(data_clk), .phase(phase),
    .phase_stb(phase_stb), .stretching(stretching), .timeout(timeout)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an integer position within the bit period plus the
  // run length of consecutive held edges, following the stated rules directly.
  int   m_pos = 4 * D - 1;
  int   m_run = 0;
  logic m_to = 0;
  logic [6:0] m_exp = '0;
  bit   model_on = 0;

  always @(posedge clk) begin
    int np, ph;
    bit held_edge;
    if (rst || !ena) begin
      if (rst) model_on = 1;
      m_pos = 4 * D - 1;
      m_run = 0;
      m_to  = 0;
      m_exp = '0;
    end else begin
      held_edge = 0;
      if (m_pos == 2 * D && scl_in == 1'b0 && !m_to) begin
        if (m_run < TO) held_edge = 1;
        else m_to = 1;
      end
      np    = held_edge ? m_pos : (m_pos + 1) % (4 * D);
      m_run = held_edge ? m_run + 1 : 0;
      ph    = np / D;
      m_exp = {ph < 2, ph == 1 || ph == 2, 2'(ph),
               (np % D == 0) && (np != m_pos), held_edge, m_to};
      m_pos = np;
    end
  end

  always @(negedge clk)
    if (model_on)
      check("model", {scl_oe, data_clk, phase, phase_stb, stretching, timeout}, m_exp);

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_stb(input int p, input string nm);
    bit found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      if (phase_stb && phase == 2'(p)) found = 1;
    end
    if (!found) check(nm, 0, 1);
  endtask

  typedef struct {
    logic       rst;
    logic       ena;
    logic       scl;
    logic [6:0] exp;  // {scl_oe, data_clk, phase, phase_stb, stretching, timeout}
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic r, input logic e, input logic s, input logic [6:0] x);
    vec_t v;
    v.rst = r; v.ena = e; v.scl = s; v.exp = x;
    return v;
  endfunction

  initial begin
    int per, nstr, nstb;

    tbl[0]  = mk(1, 0, 1, 7'b0000000);  // reset
    tbl[1]  = mk(0, 1, 1, 7'b1000100);  // cnt 0
    tbl[2]  = mk(0, 1, 0, 7'b1000000);  // cnt 1, scl low ignored
    tbl[3]  = mk(0, 1, 0, 7'b1000000);  // cnt 2
    tbl[4]  = mk(0, 1, 1, 7'b1000000);  // cnt 3
    tbl[5]  = mk(0, 1, 1, 7'b1101100);  // cnt 4
    tbl[6]  = mk(0, 1, 1, 7'b1101000);  // cnt 5
    tbl[7]  = mk(0, 1, 1, 7'b1101000);  // cnt 6
    tbl[8]  = mk(0, 1, 1, 7'b1101000);  // cnt 7
    tbl[9]  = mk(0, 1, 1, 7'b0110100);  // cnt 8
    tbl[10] = mk(0, 1, 0, 7'b0110010);  // hold at 8
    tbl[11] = mk(0, 1, 0, 7'b0110010);  // hold at 8
    tbl[12] = mk(0, 1, 1, 7'b0110000);  // cnt 9
    tbl[13] = mk(0, 0, 1, 7'b0000000);  // idle
    tbl[14] = mk(0, 1, 1, 7'b1000100);  // cnt 0
    tbl[15] = mk(0, 1, 1, 7'b1000000);  // cnt 1
    tbl[16] = mk(0, 1, 1, 7'b1000000);  // cnt 2
    tbl[17] = mk(0, 1, 1, 7'b1000000);  // cnt 3
    tbl[18] = mk(0, 1, 1, 7'b1101100);  // cnt 4
    tbl[19] = mk(0, 1, 1, 7'b1101000);  // cnt 5
    tbl[20] = mk(0, 1, 1, 7'b1101000);  // cnt 6
    tbl[21] = mk(1, 1, 1, 7'b0000000);  // rst mid-period
    tbl[22] = mk(0, 1, 1, 7'b1000100);  // cnt 0 after rst

    mode = 0;
    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst; ena = tbl[i].ena; scl_force = tbl[i].scl;
      step();
      check($sformatf("vec%0d", i),
            {scl_oe, data_clk, phase, phase_stb, stretching, timeout}, tbl[i].exp);
    end

    // free run, zero loop latency
    ena = 0; step(); mode = 1; ena = 1;
    wait_stb(0, "free_start");
    per = 0; nstr = 0; nstb = 0;
    for (int k = 0; k < 100; k++) begin
      step(); per++;
      if (stretching) nstr++;
      if (phase_stb) nstb++;
      if (phase_stb && phase == 2'd0) break;
    end
    check("free_period", per, 16);
    check("free_stretch", nstr, 0);
    check("free_stb", nstb, 4);

    // two-cycle loop latency
    mode = 2;
    wait_stb(0, "lat_sync1");
    wait_stb(0, "lat_sync2");
    per = 0; nstr = 0; nstb = 0;
    for (int k = 0; k < 100; k++) begin
      step(); per++;
      if (stretching) nstr++;
      if (phase_stb) nstb++;
      if (phase_stb && phase == 2'd0) break;
    end
    check("lat_period", per, 18);
    check("lat_stretch", nstr, 2);
    check("lat_stb", nstb, 4);

    // slave stretch of 10 cycles
    mode = 0; scl_force = 1;
    wait_stb(2, "str_entry");
    scl_force = 0;
    nstr = 0;
    repeat (10) begin step(); if (stretching) nstr++; end
    check("str_held", nstr, 10);
    scl_force = 1;
    step();
    check("str_release", {stretching, phase_stb, phase, timeout}, {1'b0, 1'b0, 2'd2, 1'b0});

    // stuck-low bus times out
    wait_stb(0, "to_sync");
    scl_force = 0;
    wait_stb(2, "to_entry");
    nstr = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!stretching) break;
      nstr++;
    end
    check("to_held", nstr, TO);
    check("to_flag", {timeout, phase}, {1'b1, 2'd2});
    nstr = 0;
    repeat (48) begin step(); if (stretching) nstr++; end
    check("to_no_rehold", nstr, 0);
    check("to_sticky", timeout, 1);

    // clear timeout by idling for one cycle
    ena = 0; step();
    check("clr_idle", {timeout, scl_oe, phase_stb}, 3'b000);
    ena = 1; scl_force = 1; step();
    check("clr_restart", {phase_stb, phase, scl_oe}, {1'b1, 2'd0, 1'b1});

    // random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      if (($urandom % 8) == 0) scl_force = ~scl_force;
      if (($urandom % 600) == 0) scl_force = 0;
      ena = (($urandom % 150) != 0);
      rst = (($urandom % 400) == 0);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
